// File: rtl/spart_driver_if.sv
// SPART processor-side control bus: chip select, direction, address, status lines.
// The 8-bit data bus is a separate inout port on the driver.
interface spart_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (
    output iocs, iorw, ioaddr,
    input  rda, tbr
  );

  modport slave (
    input  iocs, iorw, ioaddr,
    output rda, tbr
  );
endinterface

// File: rtl/spart_driver.sv
// SPART bus master: divisor setup, status polling, echo FIFO, rx strobe.
// Build option UPPERCASE_EN folds a..z to A..Z on the echo path only.
module spart_driver #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    br_cfg,
  spart_driver_if.master                bus,
  inout  wire  [7:0]                    databus,
  output logic [7:0]                    rx_byte,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    CFG_LO, CFG_HI, IDLE, RD, WR
  } state_t;

  state_t state, state_nx;

  logic          armed;
  logic [7:0]    db_hi;
  logic          rda_q;
  logic          tx_ready;
  logic          tbr_low;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] head, tail;
  logic [15:0]   div;
  logic          iocs, iorw;
  logic [1:0]    ioaddr;
  logic [7:0]    dout;
  logic          in_lo, in_poll, in_rd, in_wr;
  logic          full, empty, rise;
  logic [7:0]    push_byte;

  always_comb begin
    div = 16'h12C0;
    unique case (br_cfg)
      2'b00: div = 16'h12C0;
      2'b01: div = 16'h2580;
      2'b10: div = 16'h4B00;
      2'b11: div = 16'h9600;
      default: div = 16'h12C0;
    endcase
  end

  assign full  = (fifo_count == FULL);
  assign empty = (fifo_count == '0);
  assign rise  = bus.rda & ~rda_q;

`ifdef UPPERCASE_EN
  assign push_byte = (databus >= 8'h61 && databus <= 8'h7A) ?
                     databus - 8'h20 : databus;
`else
  assign push_byte = databus;
`endif

  // armed=0 holds the bus in its reset posture for the first cycle
  always_comb begin
    state_nx = state;
    iocs     = armed;
    iorw     = 1'b1;
    ioaddr   = 2'b01;
    dout     = 8'h00;
    in_lo    = 1'b0;
    in_poll  = 1'b0;
    in_rd    = 1'b0;
    in_wr    = 1'b0;
    if (armed) begin
      unique case (state)
        CFG_LO: begin
          iorw     = 1'b0;
          ioaddr   = 2'b10;
          dout     = div[7:0];
          in_lo    = 1'b1;
          state_nx = CFG_HI;
        end
        CFG_HI: begin
          iorw     = 1'b0;
          ioaddr   = 2'b11;
          dout     = db_hi;
          state_nx = IDLE;
        end
        IDLE: begin
          in_poll = 1'b1;
          if (rise)
            state_nx = RD;
          else if (!empty && tx_ready)
            state_nx = WR;
        end
        RD: begin
          ioaddr   = 2'b00;
          in_rd    = 1'b1;
          state_nx = IDLE;
        end
        WR: begin
          iorw     = 1'b0;
          ioaddr   = 2'b00;
          dout     = mem[head];
          in_wr    = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = CFG_LO;
      endcase
    end
  end

  assign bus.iocs   = iocs;
  assign bus.iorw   = iorw;
  assign bus.ioaddr = ioaddr;
  assign databus    = iorw ? 8'bz : dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed      <= 1'b0;
      state      <= CFG_LO;
      db_hi      <= 8'h00;
      rda_q      <= 1'b0;
      tx_ready   <= 1'b1;
      tbr_low    <= 1'b0;
      rx_byte    <= 8'h00;
      rx_valid   <= 1'b0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      head       <= '0;
      tail       <= '0;
    end else begin
      armed    <= 1'b1;
      state    <= state_nx;
      rx_valid <= 1'b0;
      if (in_lo)
        db_hi <= div[15:8];
      if (in_poll || in_rd)
        rda_q <= bus.rda;
      if (in_rd) begin
        rx_byte  <= databus;
        rx_valid <= 1'b1;
        if (!full) begin
          tail       <= tail + 1'b1;
          fifo_count <= fifo_count + 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
      // tx_ready re-arms only after tbr drops and rises again
      if (in_wr) begin
        head       <= head + 1'b1;
        fifo_count <= fifo_count - 1'b1;
        tx_ready   <= 1'b0;
        tbr_low    <= 1'b0;
      end else if (!tx_ready) begin
        if (!bus.tbr) begin
          tbr_low <= 1'b1;
        end else if (tbr_low) begin
          tx_ready <= 1'b1;
          tbr_low  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_rd && !full)
      mem[tail] <= push_byte;
  end
endmodule
